// File: rtl/time_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : time_display_scanner
//  Description : Samples hours/minutes/seconds once per refresh frame.
//                Converts two fields to BCD with a subtract-by-10 FSM.
//                Drives a 4-digit multiplexed 7-segment display.
//                Adds a 1 Hz blinking colon and leading-zero blanking on hours.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_display_scanner #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Clk_1sec,
    input  logic       show_hm,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [5:0] hours,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int                 c_CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CONV_HI = 2'd1;
    localparam logic [1:0] c_ST_CONV_LO = 2'd2;
    localparam logic [1:0] c_ST_COMMIT  = 2'd3;

    logic [c_CNT_W-1:0] r_scan_cnt;
    logic [1:0]         r_digit_sel;
    logic               w_frame_start;

    logic               r_old_clk_1sec;
    logic               r_blink;

    logic [1:0]         r_state;
    logic [5:0]         r_work_hi;
    logic [5:0]         r_work_lo;
    logic [3:0]         r_hi_tens;
    logic [3:0]         r_hi_ones;
    logic [3:0]         r_lo_tens;
    logic [3:0]         r_lo_ones;
    logic               r_mode_lat;

    logic [3:0]         r_d3;
    logic [3:0]         r_d2;
    logic [3:0]         r_d1;
    logic [3:0]         r_d0;
    logic               r_disp_hm;

    logic [5:0]         w_hi_sel;
    logic [5:0]         w_lo_sel;
    logic [3:0]         w_digit;
    logic               w_blank;

    // BCD digit to {g,f,e,d,c,b,a}; values above 9 never reach here
    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_frame_start = (r_digit_sel == 2'd3) && (r_scan_cnt == c_CNT_MAX);
    assign w_hi_sel      = show_hm ? hours   : minutes;
    assign w_lo_sel      = show_hm ? minutes : seconds;

    // Per-digit dwell counter and digit selector
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= 2'd0;
        end else if (r_scan_cnt == c_CNT_MAX) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + 1'b1;
        end
    end

    // History of Clk_1sec; kept running through reset so a level already high at release is not seen as an edge
    always_ff @(posedge clk) begin
        r_old_clk_1sec <= Clk_1sec;
    end

    // Colon blink toggles once per rising edge of the 1 Hz input
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink <= 1'b0;
        end else if (Clk_1sec && !r_old_clk_1sec) begin
            r_blink <= ~r_blink;
        end
    end

    // Sequential binary-to-BCD conversion of the hi and lo fields, one frame at a time
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_work_hi  <= '0;
            r_work_lo  <= '0;
            r_hi_tens  <= '0;
            r_hi_ones  <= '0;
            r_lo_tens  <= '0;
            r_lo_ones  <= '0;
            r_mode_lat <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_frame_start) begin
                        r_work_hi  <= w_hi_sel;
                        r_work_lo  <= w_lo_sel;
                        r_mode_lat <= show_hm;
                        r_hi_tens  <= '0;
                        r_lo_tens  <= '0;
                        r_state    <= c_ST_CONV_HI;
                    end
                end
                c_ST_CONV_HI: begin
                    if (r_work_hi >= 6'd10) begin
                        r_work_hi <= r_work_hi - 6'd10;
                        r_hi_tens <= r_hi_tens + 4'd1;
                    end else begin
                        r_hi_ones <= r_work_hi[3:0];
                        r_state   <= c_ST_CONV_LO;
                    end
                end
                c_ST_CONV_LO: begin
                    if (r_work_lo >= 6'd10) begin
                        r_work_lo <= r_work_lo - 6'd10;
                        r_lo_tens <= r_lo_tens + 4'd1;
                    end else begin
                        r_lo_ones <= r_work_lo[3:0];
                        r_state   <= c_ST_COMMIT;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // All four digits and the mode are committed together so the display never tears
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d3      <= '0;
            r_d2      <= '0;
            r_d1      <= '0;
            r_d0      <= '0;
            r_disp_hm <= 1'b1;
        end else if (r_state == c_ST_COMMIT) begin
            r_d3      <= r_hi_tens;
            r_d2      <= r_hi_ones;
            r_d1      <= r_lo_tens;
            r_d0      <= r_lo_ones;
            r_disp_hm <= r_mode_lat;
        end
    end

    // Select the committed digit for the active position and decide leading-zero blanking
    always_comb begin
        w_digit = r_d0;
        case (r_digit_sel)
            2'd0:    w_digit = r_d0;
            2'd1:    w_digit = r_d1;
            2'd2:    w_digit = r_d2;
            default: w_digit = r_d3;
        endcase
        w_blank = r_disp_hm && (r_d3 == 4'd0) && (r_digit_sel == 2'd3);
    end

    // Registered display drive: anode, segments and colon
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= 7'h00;
            dp  <= 1'b0;
            an  <= 4'b1111;
        end else begin
            an  <= ~(4'b0001 << r_digit_sel);
            seg <= w_blank ? 7'h00 : f_seg7(w_digit);
            dp  <= (r_digit_sel == 2'd2) && r_blink;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_display_scanner
//  Description : Self-checking bench for time_display_scanner (SCAN_DIV=16).
//                Digit windows: edge k after reset release shows digit
//                ((k-1)/16)%4; the first frame latch is at edge 64.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_display_scanner;

    localparam int c_SD = 16;

    logic       clk;
    logic       reset;
    logic       Clk_1sec;
    logic       show_hm;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [5:0] hours;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    time_display_scanner #(.SCAN_DIV(c_SD)) dut (
        .clk      (clk),
        .reset    (reset),
        .Clk_1sec (Clk_1sec),
        .show_hm  (show_hm),
        .seconds  (seconds),
        .minutes  (minutes),
        .hours    (hours),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             hm;
        logic [5:0]       h;
        logic [5:0]       m;
        logic [5:0]       s;
        logic [3:0][6:0]  e;   // e[3] = leftmost digit
    } vec_t;

    typedef struct {
        int         at;
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    vec_t  vecs[8];
    exp_t  exp_q[$];
    int    k;
    int    total;
    int    bad;

    task automatic run_to(input int at);
        if (at > k) begin
            while (k < at) begin
                @(posedge clk);
                k++;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_now(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        total++;
        if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
            bad++;
            $display("FAIL %s k=%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                     tag, k, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    task automatic push(input int at, input string tag, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        exp_q.push_back('{at, tag, e_an, e_seg, e_dp});
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            run_to(e.at);
            check_now(e.tag, e.an, e.seg, e.dp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
    endtask

    task automatic set_in(input logic hm, input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        show_hm = hm;
        hours   = h;
        minutes = m;
        seconds = s;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        k        = 0;
        reset    = 1'b1;
        Clk_1sec = 1'b0;
        set_in(1'b1, 6'd0, 6'd0, 6'd0);

        vecs[0] = '{1'b1, 6'd13, 6'd7,  6'd0,  {7'h06, 7'h4F, 7'h3F, 7'h07}};
        vecs[1] = '{1'b1, 6'd5,  6'd42, 6'd0,  {7'h00, 7'h6D, 7'h66, 7'h5B}};
        vecs[2] = '{1'b0, 6'd0,  6'd59, 6'd58, {7'h6D, 7'h6F, 7'h6D, 7'h7F}};
        vecs[3] = '{1'b0, 6'd9,  6'd0,  6'd0,  {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[4] = '{1'b1, 6'd23, 6'd59, 6'd1,  {7'h5B, 7'h4F, 7'h6D, 7'h6F}};
        vecs[5] = '{1'b1, 6'd0,  6'd0,  6'd30, {7'h00, 7'h3F, 7'h3F, 7'h3F}};
        vecs[6] = '{1'b0, 6'd1,  6'd60, 6'd63, {7'h7D, 7'h3F, 7'h7D, 7'h4F}};
        vecs[7] = '{1'b1, 6'd10, 6'd9,  6'd44, {7'h06, 7'h3F, 7'h3F, 7'h6F}};

        // Reset state and first cycle after release
        do_reset();
        push(0, "reset_state", 4'b1111, 7'h00, 1'b0);
        push(1, "first_cycle", 4'b1110, 7'h3F, 1'b0);
        drain();

        // Table: values shown during the second frame after release
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_in(vecs[i].hm, vecs[i].h, vecs[i].m, vecs[i].s);
            push(137, $sformatf("vec%0d_d0", i), 4'b1110, vecs[i].e[0], 1'b0);
            push(153, $sformatf("vec%0d_d1", i), 4'b1101, vecs[i].e[1], 1'b0);
            push(169, $sformatf("vec%0d_d2", i), 4'b1011, vecs[i].e[2], 1'b0);
            push(185, $sformatf("vec%0d_d3", i), 4'b0111, vecs[i].e[3], 1'b0);
            drain();
        end

        // Worst-case-ish latency: 59/58 latched at edge 64, commit at edge 77, seg switches at edge 78
        do_reset();
        set_in(1'b0, 6'd0, 6'd59, 6'd58);
        push(77, "lat_before", 4'b1110, 7'h3F, 1'b0);
        push(78, "lat_after",  4'b1110, 7'h7F, 1'b0);
        drain();

        // Input change mid-frame only shows after the next commit
        do_reset();
        set_in(1'b0, 6'd0, 6'd12, 6'd0);
        run_to(100);
        minutes = 6'd34;
        push(105, "mid_old_d2", 4'b1011, 7'h5B, 1'b0);
        push(121, "mid_old_d3", 4'b0111, 7'h06, 1'b0);
        push(137, "mid_new_d0", 4'b1110, 7'h3F, 1'b0);
        push(169, "mid_new_d2", 4'b1011, 7'h66, 1'b0);
        push(185, "mid_new_d3", 4'b0111, 7'h4F, 1'b0);
        drain();

        // Colon: level high through reset is ignored; a held-high pulse toggles once
        Clk_1sec = 1'b1;
        do_reset();
        set_in(1'b1, 6'd13, 6'd7, 6'd0);
        push(41, "colon_rst_edge", 4'b1011, 7'h3F, 1'b0);
        drain();
        run_to(45);
        Clk_1sec = 1'b0;
        run_to(50);
        Clk_1sec = 1'b1;
        run_to(60);
        Clk_1sec = 1'b0;
        push(73,  "colon_d0", 4'b1110, 7'h07, 1'b0);
        push(89,  "colon_d1", 4'b1101, 7'h3F, 1'b0);
        push(105, "colon_d2", 4'b1011, 7'h4F, 1'b1);
        push(121, "colon_d3", 4'b0111, 7'h06, 1'b0);
        drain();
        run_to(130);
        Clk_1sec = 1'b1;
        run_to(135);
        Clk_1sec = 1'b0;
        push(169, "colon_off", 4'b1011, 7'h4F, 1'b0);
        drain();

        // Reset during CONV_LO (23/59: hi done by edge 67, lo subtracting at edge 70)
        do_reset();
        set_in(1'b1, 6'd23, 6'd59, 6'd0);
        run_to(69);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_now("rst_conv_lo", 4'b1111, 7'h00, 1'b0);
        reset = 1'b0;
        k = 0;
        push(1,   "rst_post_d0",  4'b1110, 7'h3F, 1'b0);
        push(41,  "rst_post_d2",  4'b1011, 7'h3F, 1'b0);
        push(57,  "rst_post_d3",  4'b0111, 7'h00, 1'b0);
        push(185, "rst_commit_d3", 4'b0111, 7'h5B, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
